// File: rtl/ex_sched.sv
// ex_sched: execute-stage scheduler for the 16-bit core's ALU.
//
// Buffers decoded ALU instructions in a small circular FIFO, issues at most one per cycle
// by driving the register-file read addresses and the ALU op/select controls, and holds
// the registered ALU result (exout) that both feeds writeback and serves as the
// forwarding source for back-to-back dependent instructions.
//
// Build option:
//   EX_SCHED_FWD_EN  defined   -> distance-1 hazards are forwarded via alu_select, no stalls.
//                    undefined -> alu_select stays 00; a distance-1 hazard stalls one cycle
//                                 so the producer's writeback lands in the register file.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), asynchronous active-high reset
//   i_in_valid / o_in_ready      decode handshake; transfer when both high
//   i_in_op                      01 add, 10 and, 00/11 NOP
//   i_in_rd, i_in_rs1, i_in_rs2  destination and source register addresses
//   i_flush                      synchronous discard of buffered and in-flight work
//   o_rf_ra, o_rf_rb             register-file read addresses (ALU ain/bin)
//   o_alu_op, o_alu_select       ALU controls; select bit1 = A from exout, bit0 = B from exout
//   o_alu_go                     an instruction issues this cycle
//   i_alu_result                 combinational ALU result
//   o_exout                      registered previous ALU result
//   o_wb_valid, o_wb_rd, o_wb_data  register-file write port (always accepted)

module ex_sched #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_in_op,
  input  logic [REG_AW-1:0] i_in_rd,
  input  logic [REG_AW-1:0] i_in_rs1,
  input  logic [REG_AW-1:0] i_in_rs2,
  input  logic              i_flush,
  output logic [REG_AW-1:0] o_rf_ra,
  output logic [REG_AW-1:0] o_rf_rb,
  output logic [1:0]        o_alu_op,
  output logic [1:0]        o_alu_select,
  output logic              o_alu_go,
  input  logic [15:0]       i_alu_result,
  output logic [15:0]       o_exout,
  output logic              o_wb_valid,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic [15:0]       o_wb_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = 2 + 3 * REG_AW;

  // FIFO storage and state
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  // Execute register
  logic [15:0]       r_exout;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_valid;

  // Head-of-FIFO fields
  logic [1:0]        w_head_op;
  logic [REG_AW-1:0] w_head_rd;
  logic [REG_AW-1:0] w_head_rs1;
  logic [REG_AW-1:0] w_head_rs2;

  logic              w_nonempty;
  logic              w_full;
  logic              w_hz_a;
  logic              w_hz_b;
  logic              w_stall;
  logic [1:0]        w_sel;
  logic              w_issue;
  logic              w_push;
  logic              w_head_writes;
  logic [CNT_W-1:0]  w_count_nxt;

  assign {w_head_op, w_head_rd, w_head_rs1, w_head_rs2} = r_mem[r_rptr];

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));

  // Distance-1 hazard: a source matches the result currently sitting in exout.
  // Distance >= 2 is already in the register file, so nothing to do there.
  assign w_hz_a = r_ex_valid && (w_head_rs1 == r_ex_rd);
  assign w_hz_b = r_ex_valid && (w_head_rs2 == r_ex_rd);

`ifdef EX_SCHED_FWD_EN
  assign w_stall = 1'b0;
  assign w_sel   = {w_hz_a, w_hz_b};
`else
  // The bubble clears ex_valid, so the retry next cycle sees no hazard and reads the
  // freshly written register file.
  assign w_stall = w_hz_a | w_hz_b;
  assign w_sel   = 2'b00;
`endif

  assign w_issue       = w_nonempty && !i_flush && !w_stall;
  // A push coinciding with flush is dropped.
  assign w_push        = i_in_valid && !w_full && !i_flush;
  // NOPs issue but never write back and never become a forwarding source.
  assign w_head_writes = (w_head_op == 2'b01) || (w_head_op == 2'b10);

  // in_ready depends only on registered occupancy.
  assign o_in_ready = !w_full;

  always_comb begin
    o_alu_go     = w_issue;
    o_alu_op     = 2'b00;
    o_alu_select = 2'b00;
    o_rf_ra      = '0;
    o_rf_rb      = '0;
    if (w_nonempty) begin
      o_rf_ra = w_head_rs1;
      o_rf_rb = w_head_rs2;
    end
    if (w_issue) begin
      o_alu_op     = w_head_op;
      o_alu_select = w_sel;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_issue})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Payload storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_in_op, i_in_rd, i_in_rs1, i_in_rs2};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_exout    <= '0;
      r_ex_rd    <= '0;
      r_ex_valid <= 1'b0;
    end else if (i_flush) begin
      // exout and ex_rd deliberately hold across a flush.
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ex_valid <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_issue) begin
        r_rptr     <= r_rptr + PTR_W'(1);
        r_exout    <= i_alu_result;
        r_ex_rd    <= w_head_rd;
        r_ex_valid <= w_head_writes;
      end else begin
        r_ex_valid <= 1'b0;
      end
      r_count <= w_count_nxt;
    end
  end

  assign o_exout    = r_exout;
  assign o_wb_valid = r_ex_valid;
  assign o_wb_rd    = r_ex_rd;
  assign o_wb_data  = r_exout;

endmodule
